// File: rtl/panel_io_ctrl.sv
// Front-panel controller: button debounce and press events, LED mode mux with blink/heartbeat, beep burst sequencer.
// Optional PANEL_BTN_CLICK_EN: a debounced press in IDLE starts a single-beep click.
module panel_io_ctrl #(
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int BEEP_HALF_CYC = 25_000,
  parameter int BEEP_ON_CYC   = 10_000_000,
  parameter int BEEP_OFF_CYC  = 10_000_000,
  parameter int BLINK_CYC     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  input  logic [5:0] led_sw,
  input  logic [1:0] led_mode,
  output logic [5:0] LEDS,
  input  logic       beep_start,
  input  logic [3:0] beep_count,
  output logic       beep_busy,
  output logic       Beep
);

  localparam int DUR_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TONE_W  = (BEEP_HALF_CYC > 1) ? $clog2(BEEP_HALF_CYC) : 1;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int BLK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(BEEP_HALF_CYC - 1);
  localparam logic [DUR_W-1:0]  ON_LAST   = DUR_W'(BEEP_ON_CYC - 1);
  localparam logic [DUR_W-1:0]  OFF_LAST  = DUR_W'(BEEP_OFF_CYC - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]        level_q, level_d, press_q, press_d;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [DB_W-1:0]   db_cnt_d [2];
  logic [1:0]        pressed;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic [5:0]        leds_q, leds_d;
  logic [1:0]        state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              beep_q, beep_d;
  logic              start_ok;
  logic [3:0]        start_cnt;

  // Buttons: raw pins are active-low, so the synchronisers idle at 1 (released).
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    pressed = ~sync2_q;
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) level_d[i] = pressed[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    case (led_mode)
      2'd0:    leds_d = led_sw;
      2'd1:    leds_d = {led_sw[5:1], blink_q};
      2'd2:    leds_d = {6{blink_q}};
      default: leds_d = 6'd0;
    endcase
  end

  // beep_start is a one-cycle request sampled only in IDLE; beep_busy rises the
  // cycle after acceptance and falls with the final forced-low Beep. No queueing.
  always_comb begin
    start_ok  = beep_start && (beep_count != 4'd0);
    start_cnt = beep_count;
`ifdef PANEL_BTN_CLICK_EN
    if (!start_ok && (press_q != 2'b00)) begin
      start_ok  = 1'b1;
      start_cnt = 4'd1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    beep_d  = beep_q;
    case (state_q)
      S_IDLE: begin
        beep_d = 1'b0;
        if (start_ok) begin
          state_d = S_ON;
          rem_d   = start_cnt;
          dur_d   = '0;
          tone_d  = '0;
          beep_d  = 1'b1;
        end
      end
      S_ON: begin
        dur_d = dur_q + 1'b1;
        if (tone_q == TONE_LAST) begin
          tone_d = '0;
          beep_d = ~beep_q;
        end else begin
          tone_d = tone_q + 1'b1;
        end
        if (dur_q == ON_LAST) begin
          rem_d   = rem_q - 4'd1;
          dur_d   = '0;
          tone_d  = '0;
          beep_d  = 1'b0;
          state_d = (rem_q == 4'd1) ? S_IDLE : S_OFF;
        end
      end
      S_OFF: begin
        beep_d = 1'b0;
        dur_d  = dur_q + 1'b1;
        if (dur_q == OFF_LAST) begin
          state_d = S_ON;
          dur_d   = '0;
          tone_d  = '0;
          beep_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        beep_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      level_q     <= 2'b00;
      press_q     <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      leds_q      <= 6'd0;
      state_q     <= S_IDLE;
      rem_q       <= 4'd0;
      dur_q       <= '0;
      tone_q      <= '0;
      beep_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      leds_q      <= leds_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      dur_q       <= dur_d;
      tone_q      <= tone_d;
      beep_q      <= beep_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign LEDS      = leds_q;
  assign beep_busy = (state_q != S_IDLE);
  assign Beep      = beep_q;

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Self-checking bench for panel_io_ctrl with small parameters and a behavioural reference model.
module tb_panel_io_ctrl;

  localparam int DEB  = 4;
  localparam int HALF = 2;
  localparam int ON   = 8;
  localparam int OFF  = 4;
  localparam int BLK  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press;
  logic [5:0] led_sw;
  logic [1:0] led_mode;
  logic [5:0] LEDS;
  logic       beep_start;
  logic [3:0] beep_count;
  logic       beep_busy;
  logic       Beep;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  panel_io_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .BEEP_HALF_CYC(HALF),
    .BEEP_ON_CYC  (ON),
    .BEEP_OFF_CYC (OFF),
    .BLINK_CYC    (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .led_sw    (led_sw),
    .led_mode  (led_mode),
    .LEDS      (LEDS),
    .beep_start(beep_start),
    .beep_count(beep_count),
    .beep_busy (beep_busy),
    .Beep      (Beep)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    beep_start = 1'b0;
    btn_raw    = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  // reference model
  function automatic logic blink_at(int k);
    return ((k / BLK) % 2) == 1;
  endfunction

  function automatic logic [5:0] leds_model(logic [1:0] m, logic [5:0] sw, logic b);
    case (m)
      2'd0:    return sw;
      2'd1:    return {sw[5:1], b};
      2'd2:    return {6{b}};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic tone_at(int j);
    return ((j / HALF) % 2) == 0;
  endfunction

  logic exp_q[$];

  task automatic build_burst(int n);
    exp_q.delete();
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < ON; j++) exp_q.push_back(tone_at(j));
      if (b < n - 1) for (int j = 0; j < OFF; j++) exp_q.push_back(1'b0);
    end
  endtask

  // tests
  task automatic test_reset();
    logic [11:0] obs;
    logic [5:0]  exp_leds;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      btn_raw    = 2'($urandom_range(0, 3));
      led_sw     = 6'($urandom);
      led_mode   = 2'($urandom_range(0, 3));
      beep_start = 1'($urandom_range(0, 1));
      beep_count = 4'($urandom);
      tick();
      obs = {LEDS, Beep, beep_busy, btn_level, btn_press};
      total_cnt++;
      if (obs !== 12'd0) $display("FAIL reset_hold: got %h expected 000", obs);
      else pass_cnt++;
    end
    btn_raw    = 2'b11;
    beep_start = 1'b0;
    led_mode   = 2'd2;
    led_sw     = 6'($urandom);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      exp_leds = {6{blink_at(k - 1)}};
      tick();
      total_cnt++;
      if (LEDS !== exp_leds) $display("FAIL blink_after_reset k=%0d: got %h expected %h", k, LEDS, exp_leds);
      else pass_cnt++;
    end
  endtask

  task automatic test_leds();
    logic [5:0] exp_leds;
    for (int i = 0; i < 40; i++) begin
      if (i < 4) begin
        led_sw   = 6'h2A;
        led_mode = 2'(i);
      end else begin
        led_sw   = 6'($urandom);
        led_mode = 2'($urandom_range(0, 3));
      end
      exp_leds = leds_model(led_mode, led_sw, blink_at(cyc));
      tick();
      total_cnt++;
      if (LEDS !== exp_leds)
        $display("FAIL leds mode=%0d sw=%h: got %h expected %h", led_mode, led_sw, LEDS, exp_leds);
      else pass_cnt++;
    end
  endtask

  task automatic test_debounce();
    int L, b;
    logic [1:0] exp_lvl, exp_prs;
    for (int t = 0; t < 7; t++) begin
      L = (t == 0) ? 3 : (t == 1) ? 10 : (t == 2) ? 4 : $urandom_range(1, 10);
      b = (t < 2) ? 0 : $urandom_range(0, 1);
      btn_raw[b] = 1'b0;
      for (int c = 1; c <= L + DEB + 5; c++) begin
        if (c == L + 1) btn_raw[b] = 1'b1;
        tick();
        exp_lvl = 2'b00;
        exp_prs = 2'b00;
        exp_lvl[b] = (L >= DEB) && (c >= DEB + 2) && (c < L + DEB + 2);
        exp_prs[b] = (L >= DEB) && (c == DEB + 2);
        total_cnt++;
        if (btn_level !== exp_lvl || btn_press !== exp_prs)
          $display("FAIL debounce L=%0d bit=%0d c=%0d: got lvl=%b prs=%b expected lvl=%b prs=%b",
                   L, b, c, btn_level, btn_press, exp_lvl, exp_prs);
        else pass_cnt++;
      end
      for (int i = 0; i < 12; i++) tick();
    end
  endtask

  task automatic test_beep_burst();
    int n, len, inj;
    logic e;
    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? 2 : $urandom_range(1, 4);
      build_burst(n);
      len = exp_q.size();
      inj = (t % 2 == 1) ? $urandom_range(0, len - 2) : -1;
      beep_start = 1'b1;
      beep_count = 4'(n);
      tick();
      beep_start = 1'b0;
      beep_count = 4'($urandom);
      for (int i = 0; i < len; i++) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (Beep !== e || beep_busy !== 1'b1)
          $display("FAIL burst n=%0d i=%0d: got beep=%b busy=%b expected beep=%b busy=1", n, i, Beep, beep_busy, e);
        else pass_cnt++;
        if (i == inj) begin
          beep_start = 1'b1;
          beep_count = 4'($urandom_range(0, 15));
        end
        tick();
        beep_start = 1'b0;
      end
      total_cnt++;
      if (Beep !== 1'b0 || beep_busy !== 1'b0)
        $display("FAIL burst_end n=%0d: got beep=%b busy=%b expected 0 0", n, Beep, beep_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_count();
    beep_start = 1'b1;
    beep_count = 4'd0;
    tick();
    beep_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (Beep !== 1'b0 || beep_busy !== 1'b0)
        $display("FAIL zero_count i=%0d: got beep=%b busy=%b expected 0 0", i, Beep, beep_busy);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    w = $urandom_range(2, 20);
    beep_start = 1'b1;
    beep_count = 4'd3;
    tick();
    beep_start = 1'b0;
    for (int i = 0; i < w; i++) tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (Beep !== 1'b0 || beep_busy !== 1'b0 || LEDS !== 6'd0)
      $display("FAIL reset_mid_burst w=%0d: got beep=%b busy=%b leds=%h expected 0 0 00", w, Beep, beep_busy, LEDS);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (Beep !== 1'b0 || beep_busy !== 1'b0)
        $display("FAIL after_reset_idle i=%0d: got beep=%b busy=%b expected 0 0", i, Beep, beep_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_click();
    logic eb, ebusy;
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 11) btn_raw[0] = 1'b1;
      tick();
`ifdef PANEL_BTN_CLICK_EN
      ebusy = (c >= DEB + 3) && (c < DEB + 3 + ON);
      eb    = ebusy && tone_at(c - (DEB + 3));
`else
      ebusy = 1'b0;
      eb    = 1'b0;
`endif
      total_cnt++;
      if (Beep !== eb || beep_busy !== ebusy)
        $display("FAIL click c=%0d: got beep=%b busy=%b expected beep=%b busy=%b", c, Beep, beep_busy, eb, ebusy);
      else pass_cnt++;
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    rst        = 1'b1;
    btn_raw    = 2'b11;
    led_sw     = 6'd0;
    led_mode   = 2'd0;
    beep_start = 1'b0;
    beep_count = 4'd0;
    test_reset();
    test_leds();
    test_debounce();
    test_beep_burst();
    test_zero_count();
    test_reset_mid_burst();
    test_click();
    do_reset();
    test_leds();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
